// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the serial audio capture/playback path.
package audio_pkg;

  localparam int AUDIO_ADDR_W     = 19;
  localparam int AUDIO_BIT_PERIOD = 79;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } rec_state_e;

endpackage

// File: rtl/audio_deserializer.sv
// Synchronizes the 1-bit serial input, samples it once per bit period and packs
// eight samples LSB-first into a byte, flagged by a one-cycle byte_valid_o pulse.
module audio_deserializer #(
  parameter int BIT_PERIOD = 79
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en_i,
  input  logic       restart_i,
  input  logic       din_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);

  localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    if (restart_i) begin
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = '0;
    end else if (en_i) begin
      if (cnt_q == CNT_W'(BIT_PERIOD - 1)) begin
        cnt_d          = '0;
        shift_d[bit_q] = sync_q[1];
        bit_d          = bit_q + 3'd1;
        valid_d        = (bit_q == 3'd7);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], din_i};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = shift_q;

endmodule

// File: rtl/audio_recorder.sv
// Capture controller: writes deserialized bytes to sample memory at 0..stopPos
// through a single-entry req/ack write buffer, with sticky done/overrun status.
module audio_recorder
  import audio_pkg::*;
#(
  parameter int BIT_PERIOD = AUDIO_BIT_PERIOD,
  parameter int ADDR_W     = AUDIO_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] stopPos,
  input  logic              din,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wr_data,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  rec_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stop_q, stop_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_req_q, wr_req_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              byte_valid;
  logic [7:0]        byte_val;

  audio_deserializer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_deser (
    .clk         (clk),
    .clr         (clr),
    .en_i        (state_q == ST_CAPTURE),
    .restart_i   (start),
    .din_i       (din),
    .byte_valid_o(byte_valid),
    .byte_o      (byte_val)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    stop_d    = stop_q;
    wr_data_d = wr_data_q;
    wr_req_d  = wr_req_q;
    done_d    = done_q;
    overrun_d = overrun_q;
    if (start) begin
      state_d   = ST_CAPTURE;
      addr_d    = '0;
      stop_d    = stopPos;
      wr_req_d  = 1'b0;
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end else begin
      // Only non-final writes advance the address, so addr never passes stopPos.
      if (wr_req_q && wr_ack) begin
        wr_req_d = 1'b0;
        if (state_q == ST_CAPTURE) addr_d = addr_q + ADDR_W'(1);
      end
      unique case (state_q)
        ST_CAPTURE: begin
          if (byte_valid) begin
            if (wr_req_q) begin
              overrun_d = 1'b1;
            end else begin
              wr_data_d = byte_val;
              wr_req_d  = 1'b1;
              if (addr_q == stop_q) state_d = ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (wr_req_q && wr_ack) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      stop_q    <= '0;
      wr_data_q <= '0;
      wr_req_q  <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stop_q    <= stop_d;
      wr_data_q <= wr_data_d;
      wr_req_q  <= wr_req_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign wr_req  = wr_req_q;
  assign done    = done_q;
  assign overrun = overrun_q;
  assign busy    = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_audio_recorder.sv
// Directed bench for audio_recorder: a BIT_PERIOD=4 instance for functional
// scenarios and a BIT_PERIOD=79 instance for full-rate latency.
module tb_audio_recorder;

  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] stopPos = '0;
  logic          din = 1'b0;
  logic          wr_ack = 1'b0;

  logic [AW-1:0] addr, addr79;
  logic [7:0]    wr_data, wr_data79;
  logic          wr_req, wr_req79, busy, busy79, done, done79, overrun, overrun79;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] log_addr[$];
  logic [7:0]    log_data[$];

  always #5 clk = ~clk;

  audio_recorder #(.BIT_PERIOD(4), .ADDR_W(AW)) u_dut (
    .clk(clk), .clr(clr), .start(start), .stopPos(stopPos), .din(din),
    .addr(addr), .wr_data(wr_data), .wr_req(wr_req), .wr_ack(wr_ack),
    .busy(busy), .done(done), .overrun(overrun)
  );

  audio_recorder #(.BIT_PERIOD(79), .ADDR_W(AW)) u_dut79 (
    .clk(clk), .clr(clr), .start(start), .stopPos(stopPos), .din(din),
    .addr(addr79), .wr_data(wr_data79), .wr_req(wr_req79), .wr_ack(wr_ack),
    .busy(busy79), .done(done79), .overrun(overrun79)
  );

  // Record every accepted write of the BIT_PERIOD=4 instance.
  always @(negedge clk) begin
    if (wr_req === 1'b1 && wr_ack === 1'b1) begin
      log_addr.push_back(addr);
      log_data.push_back(wr_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [AW-1:0] stop);
    @(negedge clk);
    stopPos = stop;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int bp);
    for (int k = 0; k < 8; k++) begin
      din = b[k];
      repeat (bp) @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (wr_req !== 1'b0) begin n_err++; $display("FAIL reset_wr_req: got %b want 0", wr_req); end
    n_vec++; if (addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", addr); end
    n_vec++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    n_vec++; if ({busy, done, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy, done, overrun}); end
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0]    exp_d[3] = '{8'hA5, 8'h3C, 8'hFF};
    logic [AW-1:0] exp_a[3] = '{19'd0, 19'd1, 19'd2};
    int n;
    wr_ack = 1'b1;
    clear_log();
    pulse_start(19'd2);
    fork
      begin
        drive_byte(8'hA5, 4);
        drive_byte(8'h3C, 4);
        drive_byte(8'hFF, 4);
      end
      begin
        n = 0;
        while (wr_req !== 1'b1 && n < 100) begin
          @(posedge clk); n++; #1;
        end
        n_vec++; if (n !== 33) begin n_err++; $display("FAIL basic_latency: got %0d want 33", n); end
      end
    join
    for (int i = 0; i < 50 && done !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    n_vec++; if (log_addr.size() !== 3) begin n_err++; $display("FAIL basic_count: got %0d want 3", log_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < log_addr.size()) begin
        n_vec++;
        if (log_addr[i] !== exp_a[i] || log_data[i] !== exp_d[i]) begin
          n_err++; $display("FAIL basic_write%0d: got (%0d,%h) want (%0d,%h)", i, log_addr[i], log_data[i], exp_a[i], exp_d[i]);
        end
      end
    end
    n_vec++; if ({done, busy, overrun} !== 3'b100) begin n_err++; $display("FAIL basic_flags: got dbo=%b want 100", {done, busy, overrun}); end
    n_vec++; if (addr !== 19'd2) begin n_err++; $display("FAIL basic_final_addr: got %0d want 2", addr); end
  endtask

  task automatic test_slow_ack();
    int n;
    wr_ack = 1'b0;
    clear_log();
    pulse_start(19'd0);
    drive_byte(8'h81, 4);
    n = 0;
    while (wr_req !== 1'b1 && n < 20) begin
      @(posedge clk); n++; #1;
    end
    n_vec++; if (wr_req !== 1'b1) begin n_err++; $display("FAIL slow_req_seen: got %b want 1", wr_req); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (wr_req !== 1'b1 || addr !== '0 || wr_data !== 8'h81 || done !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL slow_hold%0d: got req=%b addr=%0d data=%h done=%b busy=%b want 1,0,81,0,1", i, wr_req, addr, wr_data, done, busy);
      end
    end
    @(posedge clk); #1 wr_ack = 1'b1;
    @(posedge clk); #1 wr_ack = 1'b0;
    n_vec++; if ({done, busy, wr_req} !== 3'b100) begin n_err++; $display("FAIL slow_after_ack: got done/busy/req=%b want 100", {done, busy, wr_req}); end
    repeat (4) @(negedge clk);
    n_vec++;
    if (log_addr.size() !== 1 || (log_addr.size() == 1 && (log_addr[0] !== '0 || log_data[0] !== 8'h81))) begin
      n_err++; $display("FAIL slow_write: got %0d writes want 1 at (0,81)", log_addr.size());
    end
  endtask

  task automatic test_overrun();
    logic [7:0]    exp_d[4] = '{8'h12, 8'h56, 8'h78, 8'h9A};
    int n;
    wr_ack = 1'b0;
    clear_log();
    pulse_start(19'd3);
    fork
      begin
        drive_byte(8'h12, 4);
        drive_byte(8'h34, 4);
        drive_byte(8'h56, 4);
        drive_byte(8'h78, 4);
        drive_byte(8'h9A, 4);
      end
      begin
        n = 0;
        while (wr_req !== 1'b1 && n < 100) begin
          @(posedge clk); n++; #1;
        end
        repeat (35) @(posedge clk);
        #1;
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        n_vec++; if (addr !== '0 || wr_data !== 8'h12) begin n_err++; $display("FAIL ovr_hold: got (%0d,%h) want (0,12)", addr, wr_data); end
        repeat (5) @(posedge clk);
        #1 wr_ack = 1'b1;
      end
    join
    for (int i = 0; i < 50 && done !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    n_vec++; if (log_addr.size() !== 4) begin n_err++; $display("FAIL ovr_count: got %0d want 4", log_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < log_addr.size()) begin
        n_vec++;
        if (log_addr[i] !== AW'(i) || log_data[i] !== exp_d[i]) begin
          n_err++; $display("FAIL ovr_write%0d: got (%0d,%h) want (%0d,%h)", i, log_addr[i], log_data[i], i, exp_d[i]);
        end
      end
    end
    n_vec++; if ({done, overrun} !== 2'b11) begin n_err++; $display("FAIL ovr_final: got done/ovr=%b want 11", {done, overrun}); end
  endtask

  task automatic test_restart();
    wr_ack = 1'b0;
    clear_log();
    pulse_start(19'd5);
    drive_byte(8'h11, 4);
    drive_byte(8'h22, 4);
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({wr_req, overrun} !== 2'b11) begin n_err++; $display("FAIL rst_pre: got req/ovr=%b want 11", {wr_req, overrun}); end
    clear_log();
    pulse_start(19'd1);
    wr_ack = 1'b1;
    n_vec++;
    if (wr_req !== 1'b0 || addr !== '0 || overrun !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL rst_cleared: got req=%b addr=%0d ovr=%b done=%b busy=%b want 0,0,0,0,1", wr_req, addr, overrun, done, busy);
    end
    drive_byte(8'h5A, 4);
    drive_byte(8'hC3, 4);
    for (int i = 0; i < 50 && done !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_vec++; if (log_addr.size() !== 2) begin n_err++; $display("FAIL rst_count: got %0d want 2", log_addr.size()); end
    if (log_addr.size() == 2) begin
      n_vec++; if (log_addr[0] !== 19'd0 || log_data[0] !== 8'h5A) begin n_err++; $display("FAIL rst_write0: got (%0d,%h) want (0,5a)", log_addr[0], log_data[0]); end
      n_vec++; if (log_addr[1] !== 19'd1 || log_data[1] !== 8'hC3) begin n_err++; $display("FAIL rst_write1: got (%0d,%h) want (1,c3)", log_addr[1], log_data[1]); end
    end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL rst_done: got %b want 1", done); end
  endtask

  task automatic test_async_clr();
    int n;
    wr_ack = 1'b0;
    clear_log();
    pulse_start(19'd0);
    drive_byte(8'hF0, 4);
    n = 0;
    while (wr_req !== 1'b1 && n < 20) begin
      @(posedge clk); n++; #1;
    end
    n_vec++; if (wr_data !== 8'hF0) begin n_err++; $display("FAIL clr_pre_data: got %h want f0", wr_data); end
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    n_vec++;
    if (wr_req !== 1'b0 || addr !== '0 || wr_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL clr_async: got req=%b addr=%0d data=%h busy=%b done=%b ovr=%b want all 0", wr_req, addr, wr_data, busy, done, overrun);
    end
    @(negedge clk);
    clr = 1'b1;
    wr_ack = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_vec++; if (log_addr.size() !== 0) begin n_err++; $display("FAIL clr_no_write: got %0d writes want 0", log_addr.size()); end
    n_vec++; if ({busy, wr_req, done} !== 3'b000) begin n_err++; $display("FAIL clr_idle: got busy/req/done=%b want 000", {busy, wr_req, done}); end
  endtask

  task automatic test_latency79();
    int n;
    wr_ack = 1'b1;
    pulse_start(19'd0);
    fork
      drive_byte(8'h55, 79);
      begin
        n = 0;
        while (wr_req79 !== 1'b1 && n < 1000) begin
          @(posedge clk); n++; #1;
        end
        n_vec++; if (n !== 633) begin n_err++; $display("FAIL lat79_cycles: got %0d want 633", n); end
        n_vec++; if (wr_data79 !== 8'h55 || addr79 !== '0) begin n_err++; $display("FAIL lat79_write: got (%0d,%h) want (0,55)", addr79, wr_data79); end
      end
    join
    repeat (3) @(negedge clk);
    n_vec++; if ({done79, busy79, overrun79} !== 3'b100) begin n_err++; $display("FAIL lat79_flags: got dbo=%b want 100", {done79, busy79, overrun79}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slow_ack();
    test_overrun();
    test_restart();
    test_async_clr();
    test_latency79();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
